// File: rtl/exe_stage_pkg.sv
// Shared encodings and widths for the execute stage: ALU commands, shift types,
// NZCV bit positions and the multiplier FSM state type.
package exe_stage_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int ADDRESS_LEN  = 32;
  localparam int MUL_ITER_DEF = 32;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exe_state_e;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: rotated 8-bit immediate, 12-bit memory offset, or the
// shifted Rm register value.
module val2_generator
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN
) (
  input  logic              imm,
  input  logic              mem_access,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  output logic [DATA_W-1:0] val2
);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                             input logic [4:0]        amt);
    // A zero amount shifts the left term out entirely, leaving v unchanged.
    return (v >> amt) | (v << (DATA_W - int'(amt)));
  endfunction

  logic [4:0] imm_rot;
  logic [4:0] sh_amt;
  logic [1:0] sh_type;

  assign imm_rot = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];

  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = rotr(DATA_W'(shift_operand[7:0]), imm_rot);
    end else if (mem_access) begin
      val2 = DATA_W'(shift_operand);
    end else begin
      case (sh_type)
        SHIFT_LSL: val2 = val_rm << sh_amt;
        SHIFT_LSR: val2 = val_rm >> sh_amt;
        SHIFT_ASR: val2 = DATA_W'($signed(val_rm) >>> sh_amt);
        default:   val2 = rotr(val_rm, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 + ALU or iterative shift-add multiplier, branch target,
// NZCV register and the EX/MEM pipeline register.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W   = REGISTER_LEN,
  parameter int ADDR_W   = ADDRESS_LEN,
  parameter int MUL_ITER = MUL_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              imm_in,
  input  logic              branch_taken_in,
  input  logic              status_we_in,
  input  logic              is_mul_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [3:0]        dest_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_in,
  output logic              stall_out,
  output logic              branch_taken_out,
  output logic [ADDR_W-1:0] branch_addr_out,
  output logic [3:0]        status_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_val_out,
  output logic [3:0]        dest_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output exe_state_e        state_dbg
);

  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  exe_state_e        state, state_next;
  logic              start_mul, mul_last;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier, mul_add, mul_acc_next;

  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] alu_b, alu_result;
  logic [DATA_W:0]   alu_sum;
  logic              alu_cin, use_adder;
  logic [3:0]        alu_flags;

  val2_generator #(.DATA_W(DATA_W)) u_val2 (
    .imm           (imm_in),
    .mem_access    (mem_read_in | mem_write_in),
    .val_rm        (val_rm_in),
    .shift_operand (shift_operand_in),
    .val2          (val2)
  );

  assign branch_taken_out = branch_taken_in;
  assign branch_addr_out  = pc_in + ADDR_W'({{(ADDR_W-26){signed_imm_in[23]}}, signed_imm_in, 2'b00});
  assign state_dbg        = state;

  always_comb begin
    alu_b      = val2;
    alu_cin    = 1'b0;
    use_adder  = 1'b0;
    alu_result = '0;
    case (exe_cmd_in)
      EXE_MOV: alu_result = val2;
      EXE_MVN: alu_result = ~val2;
      EXE_ADD: use_adder = 1'b1;
      EXE_ADC: begin use_adder = 1'b1; alu_cin = status_out[FLAG_C]; end
      EXE_SUB: begin use_adder = 1'b1; alu_b = ~val2; alu_cin = 1'b1; end
      EXE_SBC: begin use_adder = 1'b1; alu_b = ~val2; alu_cin = status_out[FLAG_C]; end
      EXE_AND: alu_result = val_rn_in & val2;
      EXE_ORR: alu_result = val_rn_in | val2;
      EXE_EOR: alu_result = val_rn_in ^ val2;
      default: alu_result = '0;
    endcase
    // Subtraction runs as Rn + ~Val2 + carry, so the carry-out is already not-borrow.
    alu_sum = {1'b0, val_rn_in} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_cin};
    if (use_adder) alu_result = alu_sum[DATA_W-1:0];
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_result[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_result == '0);
    alu_flags[FLAG_C] = use_adder ? alu_sum[DATA_W] : status_out[FLAG_C];
    alu_flags[FLAG_V] = use_adder ? ((val_rn_in[DATA_W-1] == alu_b[DATA_W-1]) &&
                                     (alu_sum[DATA_W-1] != val_rn_in[DATA_W-1]))
                                  : status_out[FLAG_V];
  end

  assign mul_add      = mul_mplier[0] ? mul_mcand : '0;
  assign mul_acc_next = mul_acc + mul_add;

  // stall_out is the only handshake: while it is high upstream holds every input
  // stable; an edge with stall_out low is an accept edge and upstream advances.
  always_comb begin
    state_next = state;
    start_mul  = is_mul_in & ~branch_taken_in;
    mul_last   = (state == ST_MUL) && (mul_cnt == CNT_LAST);
    stall_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_out = start_mul;
        if (start_mul) state_next = ST_MUL;
      end
      ST_MUL: begin
        stall_out = ~mul_last;
        if (mul_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (state == ST_IDLE) begin
      if (start_mul) begin
        mul_cnt    <= '0;
        mul_acc    <= '0;
        mul_mcand  <= val_rn_in;
        mul_mplier <= val_rm_in;
      end
    end else begin
      mul_cnt    <= mul_cnt + 1'b1;
      mul_acc    <= mul_acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

  // EX/MEM register: a bubble on multiply start, held during iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_out <= '0;
      store_val_out  <= '0;
      dest_out       <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      wb_en_out      <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start_mul) begin
        alu_result_out <= '0;
        store_val_out  <= '0;
        dest_out       <= '0;
        mem_read_out   <= 1'b0;
        mem_write_out  <= 1'b0;
        wb_en_out      <= 1'b0;
      end else begin
        alu_result_out <= alu_result;
        store_val_out  <= val_rm_in;
        dest_out       <= dest_in;
        mem_read_out   <= mem_read_in;
        mem_write_out  <= mem_write_in;
        wb_en_out      <= wb_en_in;
      end
    end else if (mul_last) begin
      alu_result_out <= mul_acc_next;
      dest_out       <= dest_in;
      wb_en_out      <= wb_en_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_out <= '0;
    end else if (status_we_in) begin
      if (state == ST_IDLE && !start_mul) begin
        status_out <= alu_flags;
      end else if (mul_last) begin
        status_out[FLAG_N] <= mul_acc_next[DATA_W-1];
        status_out[FLAG_Z] <= (mul_acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model of the
// ARM execute rules, plus directed cases for flags, Val2, branch and multiply.
module tb_exe_stage;
  import exe_stage_pkg::*;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        mr, mw, wb, imm, br, swe, mul;
    logic [31:0] rn, rm, pc;
    logic [3:0]  dest;
    logic [11:0] sh;
    logic [23:0] simm;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic        mem_read_in, mem_write_in, wb_en_in, imm_in, branch_taken_in;
  logic        status_we_in, is_mul_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_in;
  logic        stall_out, branch_taken_out;
  logic [31:0] branch_addr_out, alu_result_out, store_val_out;
  logic [3:0]  status_out, dest_out;
  logic        mem_read_out, mem_write_out, wb_en_out;
  exe_state_e  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  m_status;

  exe_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
    .imm_in(imm_in), .branch_taken_in(branch_taken_in), .status_we_in(status_we_in),
    .is_mul_in(is_mul_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .shift_operand_in(shift_operand_in), .signed_imm_in(signed_imm_in),
    .stall_out(stall_out), .branch_taken_out(branch_taken_out),
    .branch_addr_out(branch_addr_out), .status_out(status_out),
    .alu_result_out(alu_result_out), .store_val_out(store_val_out),
    .dest_out(dest_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_en_out(wb_en_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] m_ror(input logic [31:0] x, input int amt);
    logic [63:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] m_val2(input instr_t i);
    logic [31:0] x, ones;
    int amt;
    ones = '1;
    if (i.imm) return m_ror({24'd0, i.sh[7:0]}, 2 * int'(i.sh[11:8]));
    if (i.mr || i.mw) return {20'd0, i.sh};
    x   = i.rm;
    amt = int'(i.sh[11:7]);
    case (i.sh[6:5])
      2'd0:    return x << amt;
      2'd1:    return x >> amt;
      2'd2:    return (x >> amt) | (x[31] ? ~(ones >> amt) : 32'd0);
      default: return m_ror(x, amt);
    endcase
  endfunction

  function automatic logic [31:0] m_branch(input instr_t i);
    int off;
    off = $signed(i.simm);
    return i.pc + 32'(off * 4);
  endfunction

  task automatic model_alu(input instr_t i, output logic [31:0] res, output logic [3:0] fl);
    logic [31:0] v2;
    longint unsigned ua, ub, sum;
    longint sa, sb, ss, cin, brw;
    bit arith, c, v;
    v2 = m_val2(i);
    ua = 64'(i.rn); ub = 64'(v2);
    sa = longint'($signed(i.rn)); sb = longint'($signed(v2));
    cin = longint'(m_status[1]); brw = 1 - cin;
    arith = 1'b1; c = 1'b0; sum = 0; ss = 0; res = 32'd0;
    case (i.cmd)
      EXE_ADD: begin sum = ua + ub;        ss = sa + sb;        c = (sum >> 32) != 0; end
      EXE_ADC: begin sum = ua + ub + 64'(cin); ss = sa + sb + cin; c = (sum >> 32) != 0; end
      EXE_SUB: begin sum = ua - ub;        ss = sa - sb;        c = (ua >= ub); end
      EXE_SBC: begin sum = ua - ub - 64'(brw); ss = sa - sb - brw; c = (ua >= ub + 64'(brw)); end
      EXE_MOV: begin arith = 1'b0; res = v2; end
      EXE_MVN: begin arith = 1'b0; res = ~v2; end
      EXE_AND: begin arith = 1'b0; res = i.rn & v2; end
      EXE_ORR: begin arith = 1'b0; res = i.rn | v2; end
      EXE_EOR: begin arith = 1'b0; res = i.rn ^ v2; end
      default: begin arith = 1'b0; res = 32'd0; end
    endcase
    if (arith) begin
      res = sum[31:0];
      v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      fl  = {res[31], res == 32'd0, c, v};
    end else begin
      fl = {res[31], res == 32'd0, m_status[1], m_status[0]};
    end
  endtask

  // driver tasks
  task automatic apply(input instr_t i);
    pc_in = i.pc; exe_cmd_in = i.cmd; mem_read_in = i.mr; mem_write_in = i.mw;
    wb_en_in = i.wb; imm_in = i.imm; branch_taken_in = i.br; status_we_in = i.swe;
    is_mul_in = i.mul; val_rn_in = i.rn; val_rm_in = i.rm; dest_in = i.dest;
    shift_operand_in = i.sh; signed_imm_in = i.simm;
  endtask

  // Entered and left at posedge+1.
  task automatic do_normal(input instr_t i);
    logic [31:0] res;
    logic [3:0]  fl;
    apply(i);
    model_alu(i, res, fl);
    exp_q.push_back(res);
    #3;
    check("stall_normal", {31'd0, stall_out}, 32'd0);
    check("br_taken", {31'd0, branch_taken_out}, {31'd0, i.br});
    check("br_addr", branch_addr_out, m_branch(i));
    @(posedge clk); #1;
    if (i.swe) m_status = fl;
    check("alu_result", alu_result_out, exp_q.pop_front());
    check("store_val", store_val_out, i.rm);
    check("dest", {28'd0, dest_out}, {28'd0, i.dest});
    check("ctl", {29'd0, mem_read_out, mem_write_out, wb_en_out}, {29'd0, i.mr, i.mw, i.wb});
    check("status", {28'd0, status_out}, {28'd0, m_status});
  endtask

  // Multiply issued in cycle T; abort_at>0 asserts rst during cycle T+abort_at.
  task automatic do_mul(input instr_t i, input int abort_at);
    logic [63:0] p;
    instr_t bub;
    bub = '0;
    p = {32'd0, i.rn} * {32'd0, i.rm};
    exp_q.push_back(p[31:0]);
    apply(i);
    #3;
    check("mul_stall_T", {31'd0, stall_out}, 32'd1);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      check("mul_bubble_wb", {31'd0, wb_en_out}, 32'd0);
      check("mul_bubble_res", alu_result_out, 32'd0);
      check("mul_state", {31'd0, state_dbg == ST_MUL}, 32'd1);
      #3;
      check("mul_stall", {31'd0, stall_out}, {31'd0, c <= 31});
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(bub);
        m_status = 4'd0;
        exp_q.delete();
        check("abort_outs", {alu_result_out[15:0], store_val_out[7:0], dest_out, mem_read_out,
                             mem_write_out, wb_en_out, 1'b0},
              32'd0);
        check("abort_res", alu_result_out, 32'd0);
        check("abort_status", {28'd0, status_out}, 32'd0);
        check("abort_state", {31'd0, state_dbg == ST_IDLE}, 32'd1);
        #3;
        check("abort_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    if (i.swe) begin
      m_status[3] = p[31];
      m_status[2] = (p[31:0] == 32'd0);
    end
    check("mul_result", alu_result_out, exp_q.pop_front());
    check("mul_wb", {31'd0, wb_en_out}, {31'd0, i.wb});
    check("mul_dest", {28'd0, dest_out}, {28'd0, i.dest});
    check("mul_memctl", {30'd0, mem_read_out, mem_write_out}, 32'd0);
    check("mul_status", {28'd0, status_out}, {28'd0, m_status});
    check("mul_state_idle", {31'd0, state_dbg == ST_IDLE}, 32'd1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int m;
    i = '0;
    i.cmd  = 4'($urandom_range(0, 15));
    m      = $urandom_range(0, 9);
    i.mr   = (m == 0);
    i.mw   = (m == 1);
    i.wb   = 1'($urandom_range(0, 1));
    i.imm  = ($urandom_range(0, 2) == 0);
    i.br   = ($urandom_range(0, 7) == 0);
    i.swe  = 1'($urandom_range(0, 1));
    i.rn   = pick_val();
    i.rm   = pick_val();
    i.pc   = $urandom;
    i.dest = 4'($urandom_range(0, 15));
    i.sh   = 12'($urandom_range(0, 4095));
    i.simm = 24'($urandom);
    return i;
  endfunction

  initial begin
    instr_t i;
    rst = 1'b1;
    m_status = 4'd0;
    apply(rand_instr());
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", alu_result_out, 32'd0);
    check("rst_store", store_val_out, 32'd0);
    check("rst_ctl", {24'd0, dest_out, mem_read_out, mem_write_out, wb_en_out, 1'b0}, 32'd0);
    check("rst_status", {28'd0, status_out}, 32'd0);
    check("rst_state", {31'd0, state_dbg == ST_IDLE}, 32'd1);
    rst = 1'b0;

    // ADD Rn=5, #3, no flag write
    i = '0; i.cmd = EXE_ADD; i.imm = 1'b1; i.sh = 12'h003; i.rn = 32'd5; i.wb = 1'b1; i.dest = 4'd2;
    do_normal(i);
    check("add_5_3", alu_result_out, 32'd8);
    // SUBS 0 - 1
    i = '0; i.cmd = EXE_SUB; i.imm = 1'b1; i.sh = 12'h001; i.swe = 1'b1;
    do_normal(i);
    check("subs_nzcv", {28'd0, status_out}, 32'h8);
    // ADDS 0x7FFFFFFF + 1
    i = '0; i.cmd = EXE_ADD; i.imm = 1'b1; i.sh = 12'h001; i.swe = 1'b1; i.rn = 32'h7FFF_FFFF;
    do_normal(i);
    check("adds_ovf_nzcv", {28'd0, status_out}, 32'h9);
    // Val2: rotated immediate and register ROR #4
    i = '0; i.cmd = EXE_MOV; i.imm = 1'b1; i.sh = 12'h1FF;
    do_normal(i);
    check("val2_imm_rot", alu_result_out, 32'hC000_003F);
    i = '0; i.cmd = EXE_MOV; i.rm = 32'h0000_000F; i.sh = 12'h260;
    do_normal(i);
    check("val2_ror4", alu_result_out, 32'hF000_0000);
    // Branch with negative offset
    i = '0; i.br = 1'b1; i.pc = 32'h100; i.simm = 24'hFFFFFE;
    do_normal(i);
    // Branch and mul together: branch wins, no multiply
    i = '0; i.br = 1'b1; i.mul = 1'b1; i.cmd = EXE_ADD; i.rn = 32'd3; i.rm = 32'd4;
    do_normal(i);

    // Multiplies
    i = '0; i.mul = 1'b1; i.wb = 1'b1; i.dest = 4'd3; i.rn = 32'd7; i.rm = 32'd6; i.swe = 1'b1;
    do_mul(i, 0);
    check("mul_7x6", alu_result_out, 32'd42);
    i = '0; i.mul = 1'b1; i.wb = 1'b1; i.dest = 4'd4; i.rn = 32'hFFFF_FFFF; i.rm = 32'd2; i.swe = 1'b1;
    do_mul(i, 0);
    check("mul_wrap", alu_result_out, 32'hFFFF_FFFE);
    i = '0; i.mul = 1'b1; i.wb = 1'b1; i.dest = 4'd5; i.rn = 32'h1234; i.rm = 32'd0; i.swe = 1'b1;
    do_mul(i, 0);
    // Reset during multiply, then a plain ADD
    i = '0; i.mul = 1'b1; i.wb = 1'b1; i.dest = 4'd6; i.rn = 32'd9; i.rm = 32'd9;
    do_mul(i, 11);
    i = '0; i.cmd = EXE_ADD; i.imm = 1'b1; i.sh = 12'h003; i.rn = 32'd5; i.wb = 1'b1; i.dest = 4'd1;
    do_normal(i);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        i = rand_instr();
        i.mul = 1'b1; i.br = 1'b0; i.mr = 1'b0; i.mw = 1'b0;
        do_mul(i, 0);
      end else begin
        do_normal(rand_instr());
      end
    end
    for (int k = 0; k < 3; k++) begin
      i = rand_instr();
      i.mul = 1'b1; i.br = 1'b0; i.mr = 1'b0; i.mw = 1'b0;
      do_mul(i, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
